// File: rtl/usc_rv_op_queue.sv
// -----------------------------------------------------------------------------
// usc_rv_op_queue
//
// Dual-enqueue / dual-dequeue circular op buffer sitting between the decoder
// and the issue stage. Decoded ops that issue cannot take this cycle are
// parked here. Issue always sees the two oldest queued ops, and it consumes
// from a combined stream: queue entries (oldest first), then decode slot0,
// then decode slot1. Decode ops that issue takes this cycle bypass the
// queue and are never written.
//
// Ports
//   clk               core clock
//   reset             asynchronous, active-high reset
//   flush             synchronous flush; drops every queued op
//   op0_dec_v_o       decode slot0 valid (older op)
//   op0_dec_ctl_o     decode slot0 control word
//   op1_dec_v_o       decode slot1 valid (younger op); only with slot0 valid
//   op1_dec_ctl_o     decode slot1 control word
//   iss_deq_cnt       ops issue consumes this cycle from the combined stream
//   stall_de          decode must hold its ops (fewer than two free entries)
//   op0_i1_vld_raw    queue head entry valid
//   op0_i1_ctl        queue head entry
//   op1_i1_vld_raw    queue head+1 entry valid
//   op1_i1_ctl        queue head+1 entry
//   op_queue_empty    occupancy is zero
//   op_queue_one_left occupancy is exactly one
//   op_queue_cnt      occupancy
// -----------------------------------------------------------------------------
module usc_rv_op_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CTL_W = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       op0_dec_v_o,
   input  logic [CTL_W-1:0]           op0_dec_ctl_o,
   input  logic                       op1_dec_v_o,
   input  logic [CTL_W-1:0]           op1_dec_ctl_o,
   input  logic [1:0]                 iss_deq_cnt,
   output logic                       stall_de,
   output logic                       op0_i1_vld_raw,
   output logic [CTL_W-1:0]           op0_i1_ctl,
   output logic                       op1_i1_vld_raw,
   output logic [CTL_W-1:0]           op1_i1_ctl,
   output logic                       op_queue_empty,
   output logic                       op_queue_one_left,
   output logic [$clog2(DEPTH):0]     op_queue_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_TWO    = CW'(2);
   localparam logic [CW-1:0] CNT_DEPTH  = CW'(DEPTH);
   // stall when fewer than two entries are free, i.e. count >= DEPTH-1
   localparam logic [CW-1:0] CNT_STALL  = CW'(DEPTH - 1);

   // Storage: data only, deliberately not reset
   logic [CTL_W-1:0] mem_q [DEPTH];

   // Control state
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q,  cnt_d;

   // Per-cycle bookkeeping
   logic [1:0]       dec_n;       // decode ops accepted this cycle
   logic [1:0]       from_q;      // ops issue takes from the queue
   logic [1:0]       from_dec;    // ops issue takes straight from decode
   logic [CW-1:0]    cnt_calc;    // occupancy after push/pop, ignoring flush
   logic [PW-1:0]    head_p1;
   logic [PW-1:0]    tail_p1;

   logic             wr0_en, wr1_en;
   logic [CTL_W-1:0] wr0_data, wr1_data;

   // ---------------------------------------------------------------------------
   // Outputs: combinational from flops only
   // ---------------------------------------------------------------------------
   assign head_p1           = head_q + PW'(1);
   assign tail_p1           = tail_q + PW'(1);

   assign stall_de          = (cnt_q >= CNT_STALL);
   assign op0_i1_vld_raw    = (cnt_q >= CNT_ONE);
   assign op1_i1_vld_raw    = (cnt_q >= CNT_TWO);
   assign op0_i1_ctl        = mem_q[head_q];
   assign op1_i1_ctl        = mem_q[head_p1];
   assign op_queue_empty    = (cnt_q == '0);
   assign op_queue_one_left = (cnt_q == CNT_ONE);
   assign op_queue_cnt      = cnt_q;

   // ---------------------------------------------------------------------------
   // Split the issue count between queue and decode, decide writes
   // ---------------------------------------------------------------------------
   always_comb begin
      dec_n    = '0;
      from_q   = '0;
      from_dec = '0;
      wr0_en   = 1'b0;
      wr1_en   = 1'b0;
      wr0_data = op0_dec_ctl_o;
      wr1_data = op1_dec_ctl_o;

      // While stalled decode ops are neither accepted nor bypassed
      if (!stall_de) begin
         dec_n = {1'b0, op0_dec_v_o} + {1'b0, op1_dec_v_o};
      end

      // Queue is drained first; any remainder comes from the decode slots.
      // When issue asks for more than the queue holds, count is 0 or 1 so
      // its low two bits carry the whole value.
      if ({{(CW-2){1'b0}}, iss_deq_cnt} > cnt_q) begin
         from_q = cnt_q[1:0];
      end else begin
         from_q = iss_deq_cnt;
      end
      from_dec = iss_deq_cnt - from_q;

      // Unconsumed decode ops land at tail, tail+1 in age order
      if (!stall_de && !flush) begin
         case (from_dec)
            2'd0: begin
               wr0_en   = op0_dec_v_o;
               wr0_data = op0_dec_ctl_o;
               wr1_en   = op1_dec_v_o;
               wr1_data = op1_dec_ctl_o;
            end
            2'd1: begin
               // slot0 was bypassed to issue; slot1 becomes the oldest write
               wr0_en   = op1_dec_v_o;
               wr0_data = op1_dec_ctl_o;
            end
            default: begin
               wr0_en = 1'b0;
               wr1_en = 1'b0;
            end
         endcase
      end

      cnt_calc = cnt_q - {{(CW-2){1'b0}}, from_q}
                       + {{(CW-2){1'b0}}, dec_n}
                       - {{(CW-2){1'b0}}, from_dec};

      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         head_d = head_q + PW'(from_q);
         tail_d = tail_q + PW'(dec_n) - PW'(from_dec);
         cnt_d  = cnt_calc;
      end
   end

   // ---------------------------------------------------------------------------
   // Control state registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr0_en) begin
         mem_q[tail_q] <= wr0_data;
      end
      if (wr1_en) begin
         mem_q[tail_p1] <= wr1_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Illegal-usage checks
   // ---------------------------------------------------------------------------
   a_deq_not_three : assert property (@(posedge clk) disable iff (reset)
      iss_deq_cnt != 2'd3);

   a_deq_avail : assert property (@(posedge clk) disable iff (reset)
      {{(CW-2){1'b0}}, iss_deq_cnt} <= (cnt_q + {{(CW-2){1'b0}}, dec_n}));

   a_slot1_needs_slot0 : assert property (@(posedge clk) disable iff (reset)
      !(op1_dec_v_o && !op0_dec_v_o));

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      cnt_calc <= CNT_DEPTH);

endmodule

// File: tb/tb_usc_rv_op_queue.sv
// -----------------------------------------------------------------------------
// tb_usc_rv_op_queue
//
// Directed scenarios followed by randomized traffic. The reference model is
// a plain queue of control words: each cycle it forms the combined stream
// (queued ops, then accepted decode ops), hands the first iss_deq_cnt of
// them to issue, and keeps the rest in order.
// -----------------------------------------------------------------------------
module tb_usc_rv_op_queue;

   localparam int DEPTH = 8;
   localparam int CTL_W = 64;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             v0 = 1'b0;
   logic             v1 = 1'b0;
   logic [CTL_W-1:0] c0 = '0;
   logic [CTL_W-1:0] c1 = '0;
   logic [1:0]       deq = '0;

   logic             stall_de;
   logic             op0_vld, op1_vld;
   logic [CTL_W-1:0] op0_ctl, op1_ctl;
   logic             q_empty, q_one_left;
   logic [CW-1:0]    q_cnt;

   int checks = 0;
   int errors = 0;

   logic [CTL_W-1:0] mq[$];

   usc_rv_op_queue #(.DEPTH(DEPTH), .CTL_W(CTL_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .op0_dec_v_o       (v0),
      .op0_dec_ctl_o     (c0),
      .op1_dec_v_o       (v1),
      .op1_dec_ctl_o     (c1),
      .iss_deq_cnt       (deq),
      .stall_de          (stall_de),
      .op0_i1_vld_raw    (op0_vld),
      .op0_i1_ctl        (op0_ctl),
      .op1_i1_vld_raw    (op1_vld),
      .op1_i1_ctl        (op1_ctl),
      .op_queue_empty    (q_empty),
      .op_queue_one_left (q_one_left),
      .op_queue_cnt      (q_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Compare every visible output against the model queue
   task automatic check_state(input string tag);
      int n;
      n = mq.size();
      check({tag, ".cnt"},   64'(q_cnt),      64'(n));
      check({tag, ".empty"}, 64'(q_empty),    64'(n == 0));
      check({tag, ".one"},   64'(q_one_left), 64'(n == 1));
      check({tag, ".stall"}, 64'(stall_de),   64'((DEPTH - n) < 2));
      check({tag, ".vld0"},  64'(op0_vld),    64'(n >= 1));
      check({tag, ".vld1"},  64'(op1_vld),    64'(n >= 2));
      if (n >= 1) check({tag, ".ctl0"}, op0_ctl, mq[0]);
      if (n >= 2) check({tag, ".ctl1"}, op1_ctl, mq[1]);
   endtask

   // Drive one cycle, advance the model, then check
   task automatic step(input logic a_v0, input logic a_v1,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] d, input logic fl, input string tag);
      logic [63:0] dq[$];
      int          fq, fd;
      bit          st;
      v0 = a_v0; v1 = a_v1; c0 = a; c1 = b; deq = d; flush = fl;
      st = (DEPTH - mq.size()) < 2;
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (!st) begin
            if (a_v0) dq.push_back(a);
            if (a_v1) dq.push_back(b);
         end
         fq = (int'(d) > mq.size()) ? mq.size() : int'(d);
         fd = int'(d) - fq;
         repeat (fq) void'(mq.pop_front());
         repeat (fd) void'(dq.pop_front());
         foreach (dq[i]) mq.push_back(dq[i]);
      end
      v0 = 1'b0; v1 = 1'b0; deq = '0; flush = 1'b0;
      check_state(tag);
   endtask

   // One legal random cycle
   task automatic rand_step(input bit allow_flush, input string tag);
      int          n, avail, mx;
      bit          st;
      logic        rv0, rv1, fl;
      logic [1:0]  d;
      n   = mq.size();
      st  = (DEPTH - n) < 2;
      rv0 = 1'($urandom_range(0, 3) != 0);
      rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b0;
      avail = n + (st ? 0 : (int'(rv0) + int'(rv1)));
      mx  = (avail > 2) ? 2 : avail;
      d   = 2'($urandom_range(0, mx));
      fl  = allow_flush && ($urandom_range(0, 24) == 0);
      step(rv0, rv1, {$urandom, $urandom}, {$urandom, $urandom}, d, fl, tag);
   endtask

   localparam logic [63:0] A = 64'hAAAA_0000_0000_000A;
   localparam logic [63:0] B = 64'hBBBB_0000_0000_000B;
   localparam logic [63:0] C = 64'hCCCC_0000_0000_000C;
   localparam logic [63:0] X = 64'h5555_0000_0000_0058;

   initial begin
      // Reset state while reset is held
      repeat (2) @(posedge clk);
      #1;
      check("rst.cnt",   64'(q_cnt),      64'd0);
      check("rst.empty", 64'(q_empty),    64'd1);
      check("rst.one",   64'(q_one_left), 64'd0);
      check("rst.stall", 64'(stall_de),   64'd0);
      check("rst.vld0",  64'(op0_vld),    64'd0);
      check("rst.vld1",  64'(op1_vld),    64'd0);
      reset = 1'b0;

      // Full bypass: nothing enqueued
      step(1, 1, A, B, 2'd2, 0, "byp");
      check("byp.cnt0", 64'(q_cnt), 64'd0);

      // Enqueue both, then pop one while pushing C
      step(1, 1, A, B, 2'd0, 0, "enq2");
      check("enq2.h0", op0_ctl, A);
      check("enq2.h1", op1_ctl, B);
      step(1, 0, C, 64'd0, 2'd1, 0, "pp");
      check("pp.cnt", 64'(q_cnt), 64'd2);
      check("pp.h0",  op0_ctl, B);
      check("pp.h1",  op1_ctl, C);

      // Fill to DEPTH-1 and verify stall behaviour
      step(1, 1, 64'h11, 64'h12, 2'd0, 0, "fill4");
      step(1, 1, 64'h13, 64'h14, 2'd0, 0, "fill6");
      step(1, 0, 64'h15, 64'h0,  2'd0, 0, "fill7");
      check("fill7.stall", 64'(stall_de), 64'd1);
      step(1, 1, 64'h21, 64'h22, 2'd0, 0, "stall_hold");
      check("stall_hold.cnt", 64'(q_cnt), 64'd7);
      step(1, 1, 64'h23, 64'h24, 2'd2, 0, "stall_pop");
      check("stall_pop.cnt",   64'(q_cnt),    64'd5);
      check("stall_pop.stall", 64'(stall_de), 64'd0);
      for (int i = 0; i < 20; i++) rand_step(0, "wrap");

      // One entry plus two decode ops, two issued
      step(0, 0, 64'd0, 64'd0, 2'd0, 1, "fl0");
      step(1, 0, X, 64'd0, 2'd0, 0, "x");
      step(1, 1, A, B, 2'd2, 0, "mix");
      check("mix.cnt", 64'(q_cnt),      64'd1);
      check("mix.h0",  op0_ctl,         B);
      check("mix.one", 64'(q_one_left), 64'd1);

      // Flush at count 5 beats same-cycle push and pop
      step(1, 1, 64'h31, 64'h32, 2'd0, 0, "f3");
      step(1, 1, 64'h33, 64'h34, 2'd0, 0, "f5");
      check("f5.cnt", 64'(q_cnt), 64'd5);
      step(1, 1, A, B, 2'd2, 1, "flush");
      check("flush.cnt",   64'(q_cnt),    64'd0);
      check("flush.empty", 64'(q_empty),  64'd1);
      check("flush.stall", 64'(stall_de), 64'd0);

      // Long random traffic with occasional flushes
      for (int i = 0; i < 400; i++) rand_step(1, "rnd");

      // Asynchronous reset mid-burst, observed before any clock edge
      step(1, 1, A, B, 2'd0, 0, "pre_rst");
      step(1, 1, C, X, 2'd0, 0, "pre_rst2");
      reset = 1'b1;
      #1;
      check("arst.cnt",   64'(q_cnt),    64'd0);
      check("arst.empty", 64'(q_empty),  64'd1);
      check("arst.vld0",  64'(op0_vld),  64'd0);
      check("arst.stall", 64'(stall_de), 64'd0);
      mq.delete();
      @(posedge clk);
      #2;
      reset = 1'b0;
      for (int i = 0; i < 60; i++) rand_step(1, "post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
